// File: rtl/ext_mem_model_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_model_pkg
// Description : Shared types and helpers for the external memory model.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_mem_model_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_WR_WAIT = 2'd2
  } chan_state_t;

  function automatic int size_w(input int data_w);
    return $clog2(data_w) + 1;
  endfunction

  // Write-enable bits for byte lane `lane` given an access size in bits.
  function automatic logic [7:0] size_to_byte_mask(input int unsigned size,
                                                   input int unsigned data_w,
                                                   input int unsigned lane);
    int unsigned nbits;
    int unsigned lo;
    logic [7:0]  m;
    if (size == 0 || size > data_w) nbits = data_w;
    else if (size < 8)              nbits = size;
    else                            nbits = (size / 8) * 8;
    lo = lane * 8;
    if (nbits >= lo + 8)  m = 8'hFF;
    else if (nbits <= lo) m = 8'h00;
    else                  m = 8'((16'd1 << (nbits - lo)) - 16'd1);
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ext_mem_model_chan.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_model_chan
// Description : One master channel: request FSM, latency counter, read
//               snapshot and sticky error flags. EXT_MEM_MODEL_STALL_EN adds
//               0-3 LFSR-driven extra wait cycles per access.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_model_chan
  import ext_mem_model_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe,
  input  logic              we,
  input  logic              in_range,
  input  logic [DATA_W-1:0] rd_bytes,
  output logic              wr_go,
  output logic [DATA_W-1:0] rdata,
  output logic              data_rdy,
  output logic              err_conflict,
  output logic              err_range
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 4);

  chan_state_t       state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [DATA_W-1:0] snap, snap_nx;
  logic              conflict, range_bad, rdy_nx;
  logic [1:0]        stall;

`ifdef EXT_MEM_MODEL_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = lfsr[1:0];
`else
  assign stall = 2'b00;
`endif

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    snap_nx   = snap;
    conflict  = 1'b0;
    range_bad = 1'b0;
    wr_go     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (oe && we) begin
          conflict = 1'b1;
        end else if (oe || we) begin
          if (!in_range) begin
            range_bad = 1'b1;
          end else if (oe) begin
            state_nx = ST_RD_WAIT;
            cnt_nx   = CNT_W'(READ_LAT - 1) + CNT_W'(stall);
            snap_nx  = rd_bytes;
          end else begin
            wr_go    = 1'b1;
            state_nx = ST_WR_WAIT;
            cnt_nx   = CNT_W'(WRITE_LAT - 1) + CNT_W'(stall);
          end
        end
      end
      default: begin
        if (cnt == '0) state_nx = ST_IDLE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
    endcase
    // Completion is the cycle spent waiting with an exhausted counter.
    rdy_nx = (state_nx != ST_IDLE) && (cnt_nx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      snap         <= '0;
      data_rdy     <= 1'b0;
      rdata        <= '0;
      err_conflict <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      snap     <= snap_nx;
      data_rdy <= rdy_nx;
      rdata    <= (rdy_nx && state_nx == ST_RD_WAIT) ? snap_nx : '0;
      if (conflict)  err_conflict <= 1'b1;
      if (range_bad) err_range    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ext_mem_model.sv
`default_nettype none
// ============================================================================
// Module      : ext_mem_model
// Description : Multi-channel byte-addressed memory model with programmable
//               latency, size masking and preload. Optional macro
//               EXT_MEM_MODEL_STALL_EN enables random extra wait cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_mem_model
  import ext_mem_model_pkg::*;
#(
  parameter  int CHANNELS  = 2,
  parameter  int ADDR_W    = 7,
  parameter  int DATA_W    = 8,
  parameter  int MEM_BYTES = 32,
  parameter  int BASE_ADDR = 0,
  parameter  int READ_LAT  = 2,
  parameter  int WRITE_LAT = 1,
  localparam int SIZE_W    = size_w(DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CHANNELS-1:0]        oe,
  input  logic [CHANNELS-1:0]        we,
  input  logic [CHANNELS*ADDR_W-1:0] addr,
  input  logic [CHANNELS*DATA_W-1:0] wdata,
  input  logic [CHANNELS*SIZE_W-1:0] size,
  input  logic                       load_en,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic [7:0]                 load_byte,
  output logic [CHANNELS*DATA_W-1:0] rdata,
  output logic [CHANNELS-1:0]        data_rdy,
  output logic [CHANNELS-1:0]        err_conflict,
  output logic [CHANNELS-1:0]        err_range
);

  localparam int NB     = DATA_W / 8;
  localparam int MEM_AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  logic [7:0]        mem    [MEM_BYTES];
  logic [7:0]        mem_nx [MEM_BYTES];
  logic [31:0]       off    [CHANNELS];
  logic [DATA_W-1:0] rd_bytes [CHANNELS];
  logic [CHANNELS-1:0] in_range, wr_go;
  logic [31:0]       load_off, ridx, widx;
  logic              load_hit;
  logic [7:0]        bm;

  // Offsets wrap below BASE_ADDR, so one unsigned compare covers both bounds.
  always_comb begin
    ridx = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      off[c]      = 32'(addr[c*ADDR_W +: ADDR_W]) - 32'(BASE_ADDR);
      in_range[c] = off[c] < 32'(MEM_BYTES);
      rd_bytes[c] = '0;
      for (int k = 0; k < NB; k++) begin
        ridx = off[c] + 32'(k);
        if (ridx < 32'(MEM_BYTES)) rd_bytes[c][8*k +: 8] = mem[ridx[MEM_AW-1:0]];
      end
    end
  end

  assign load_off = 32'(load_addr) - 32'(BASE_ADDR);
  assign load_hit = load_en && (load_off < 32'(MEM_BYTES));

  // Preload first, then channels in ascending order so the highest index wins.
  always_comb begin
    widx = '0;
    bm   = '0;
    for (int b = 0; b < MEM_BYTES; b++) mem_nx[b] = mem[b];
    if (load_hit) mem_nx[load_off[MEM_AW-1:0]] = load_byte;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_go[c]) begin
        for (int k = 0; k < NB; k++) begin
          widx = off[c] + 32'(k);
          if (widx < 32'(MEM_BYTES)) begin
            bm = size_to_byte_mask(32'(size[c*SIZE_W +: SIZE_W]), 32'(DATA_W), 32'(k));
            mem_nx[widx[MEM_AW-1:0]] = (mem_nx[widx[MEM_AW-1:0]] & ~bm) |
                                       (wdata[c*DATA_W + 8*k +: 8] & bm);
          end
        end
      end
    end
  end

  // Contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < MEM_BYTES; b++) mem[b] <= mem_nx[b];
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    ext_mem_model_chan #(
      .DATA_W    (DATA_W),
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .oe           (oe[c]),
      .we           (we[c]),
      .in_range     (in_range[c]),
      .rd_bytes     (rd_bytes[c]),
      .wr_go        (wr_go[c]),
      .rdata        (rdata[c*DATA_W +: DATA_W]),
      .data_rdy     (data_rdy[c]),
      .err_conflict (err_conflict[c]),
      .err_range    (err_range[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_model.sv
`default_nettype none
// Randomised self-checking bench for ext_mem_model (2 channels, 16-bit data)
// against a byte-array reference model.
`timescale 1ns/1ps
module tb_ext_mem_model;

  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  oe, we;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic [9:0]  size;
  logic        load_en;
  logic [6:0]  load_addr;
  logic [7:0]  load_byte;
  logic [31:0] rdata;
  logic [1:0]  data_rdy, err_conflict, err_range;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] mem_m [32];
  logic [1:0] errc_m, errr_m;

  ext_mem_model #(
    .CHANNELS(2), .ADDR_W(7), .DATA_W(16), .MEM_BYTES(32), .BASE_ADDR(0),
    .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .oe(oe), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .load_en(load_en), .load_addr(load_addr), .load_byte(load_byte),
    .rdata(rdata), .data_rdy(data_rdy), .err_conflict(err_conflict), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input int a);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 2; k++)
      if (a + k < 32) r[8*k +: 8] = mem_m[a + k];
    return r;
  endfunction

  task automatic model_write(input int a, input logic [15:0] d, input int sz);
    int nbits;
    if (sz == 0 || sz > 16) nbits = 16;
    else if (sz < 8)        nbits = sz;
    else                    nbits = sz - (sz % 8);
    for (int i = 0; i < nbits; i++)
      if (a + i / 8 < 32) mem_m[a + i / 8][i % 8] = d[i];
  endtask

  task automatic preload(input int a, input logic [7:0] v);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 7'(a); load_byte = v;
    @(posedge clk); #1;
    load_en = 1'b0;
    if (a < 32) mem_m[a] = v;
  endtask

  task automatic access(input int ch, input bit rd, input int a, input logic [15:0] d, input int sz);
    int cyc;
    int lat;
    logic [15:0] exp_r;
    exp_r = model_read(a);
    @(posedge clk); #1;
    oe[ch] = rd; we[ch] = !rd;
    addr[ch*7 +: 7] = 7'(a); wdata[ch*16 +: 16] = d; size[ch*5 +: 5] = 5'(sz);
    @(posedge clk); #1;
    oe = '0; we = '0;
    if (!rd) model_write(a, d, sz);
    lat = rd ? READ_LAT : WRITE_LAT;
    cyc = 1;
    while (data_rdy[ch] !== 1'b1 && cyc < 12) begin
      check("rdata_wait", 32'(rdata[ch*16 +: 16]), 0);
      @(posedge clk); #1;
      cyc++;
    end
`ifdef EXT_MEM_MODEL_STALL_EN
    check("latency_range", 32'(cyc >= lat && cyc <= lat + 3), 1);
`else
    check("latency", cyc, lat);
`endif
    check(rd ? "rdata" : "wr_rdata", 32'(rdata[ch*16 +: 16]), rd ? 32'(exp_r) : 0);
    @(posedge clk); #1;
    check("rdy_pulse", 32'(data_rdy[ch]), 0);
    check("rdata_after", 32'(rdata[ch*16 +: 16]), 0);
  endtask

  task automatic bad_req(input int ch, input bit both, input int a, input bit rd);
    @(posedge clk); #1;
    oe[ch] = both | rd; we[ch] = both | !rd; addr[ch*7 +: 7] = 7'(a);
    @(posedge clk); #1;
    oe = '0; we = '0;
    if (both) errc_m[ch] = 1'b1;
    else      errr_m[ch] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("no_rdy", 32'(data_rdy), 0);
      check("no_rdata", rdata, 0);
      @(posedge clk); #1;
    end
    check("err_conflict", 32'(err_conflict), 32'(errc_m));
    check("err_range", 32'(err_range), 32'(errr_m));
  endtask

  initial begin
    logic [15:0] exp_r;
    bit seen;
    int kind, ch, a, sz;
    oe = '0; we = '0; addr = '0; wdata = '0; size = '0;
    load_en = 1'b0; load_addr = '0; load_byte = '0;
    errc_m = '0; errr_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 32'(data_rdy), 0);
    check("rst_rdata", rdata, 0);
    check("rst_errc", 32'(err_conflict), 0);
    check("rst_errr", 32'(err_range), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) preload(i, 8'($urandom));

    preload(0, 8'h11); preload(1, 8'h22); preload(2, 8'h33); preload(3, 8'h44);
    access(0, 1'b1, 0, 16'h0, 16);
    preload(5, 8'hA0);
    access(0, 1'b0, 5, 16'h00FF, 4);
    access(0, 1'b1, 5, 16'h0, 0);
    access(1, 1'b1, 31, 16'h0, 0);

    // Both channels write byte 3 on the same edge.
    @(posedge clk); #1;
    we = 2'b11; addr = {7'd3, 7'd3}; wdata = {16'h0002, 16'h0001}; size = {5'd8, 5'd8};
    @(posedge clk); #1;
    we = '0;
    mem_m[3] = 8'h02;
    repeat (6) @(posedge clk);
    #1;
    access(0, 1'b1, 3, 16'h0, 0);

    // Read and write of the same byte on the same edge.
    exp_r = model_read(2);
    @(posedge clk); #1;
    oe = 2'b01; we = 2'b10; addr = {7'd3, 7'd2}; wdata[31:16] = 16'h0055; size[9:5] = 5'd8;
    @(posedge clk); #1;
    oe = '0; we = '0;
    model_write(3, 16'h0055, 8);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!seen && data_rdy[0] === 1'b1) begin
        check("rw_same_edge", 32'(rdata[15:0]), 32'(exp_r));
        seen = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!seen) check("rw_timeout", 0, 1);
    access(1, 1'b1, 3, 16'h0, 0);

    bad_req(1, 1'b1, 4, 1'b0);
    bad_req(0, 1'b0, 40, 1'b1);
    bad_req(1, 1'b0, 100, 1'b0);
    preload(50, 8'h5A);

    // Reset while a read is pending.
    @(posedge clk); #1;
    oe[0] = 1'b1; addr[6:0] = 7'd0;
    @(posedge clk); #1;
    oe = '0;
    rst_n = 1'b0; errc_m = '0; errr_m = '0;
    for (int i = 0; i < 4; i++) begin
      check("rst_mid_rdy", 32'(data_rdy), 0);
      check("rst_mid_rdata", rdata, 0);
      @(posedge clk); #1;
    end
    check("rst_mid_errc", 32'(err_conflict), 0);
    check("rst_mid_errr", 32'(err_range), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_rdy", 32'(data_rdy), 0);
      @(posedge clk); #1;
    end
    access(0, 1'b1, 0, 16'h0, 0);

    for (int it = 0; it < 100; it++) begin
      kind = $urandom_range(0, 9);
      ch   = $urandom_range(0, 1);
      a    = $urandom_range(0, 31);
      sz   = $urandom_range(0, 31);
      case (kind)
        0:       bad_req(ch, 1'b1, a, 1'b0);
        1:       bad_req(ch, 1'b0, $urandom_range(32, 127), 1'($urandom));
        2:       preload($urandom_range(0, 40), 8'($urandom));
        3, 4, 5: access(ch, 1'b1, a, 16'h0, 0);
        default: access(ch, 1'b0, a, 16'($urandom), sz);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
